rv_muldiv_seq: RTL and testbench
================================

RV_MULDIV_SEQ -- requirements
Module: rv_muldiv_seq

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 5, the width of the destination tag carried with each operation.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port flush, input, 1: abort any in-flight operation.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-006 SHALL have port in_op, input, rv_inst_32m: the operation, MUL through REMU or RV_32M_UNDEF.
REQ-007 SHALL have ports in_rs1 and in_rs2, input, 32 each: the operands.
REQ-008 SHALL have port in_tag, input, TAG_WIDTH: the destination tag.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-010 SHALL have port out_result, output, 32: the result.
REQ-011 SHALL have port out_tag, output, TAG_WIDTH: the captured in_tag.
REQ-012 SHALL have port out_illegal, output, 1: set when the operation was RV_32M_UNDEF.
REQ-013 SHALL have port busy, output, 1: high in any state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV and DONE.
REQ-015 SHALL drive in_ready = !flush && (IDLE || (DONE && out_ready)).
REQ-016 SHALL treat acceptance as in_valid && in_ready at edge N, which captures the operands, op and tag.
REQ-017 SHALL make a MUL/MULH/MULHSU/MULHU operation enter MUL: radix-2 shift-add on operand magnitudes for exactly 32 cycles, then DONE; out_valid first high in cycle N+33.
REQ-018 SHALL compute MULH as signed×signed, MULHSU as rs1 signed × rs2 unsigned, and MULHU as unsigned; the 64-bit product is negated when the operand signs differ; MUL returns product[31:0], the others return product[63:32].
REQ-019 SHALL make a DIV/DIVU/REM/REMU operation enter DIV: restoring division on magnitudes for 32 cycles, then DONE; out_valid first high in cycle N+33.
REQ-020 SHALL give the quotient the sign rs1^rs2 and the remainder the sign of rs1 (signed ops only).
REQ-021 SHALL treat division by zero specially: go directly to DONE, out_valid in N+1, quotient 0xFFFFFFFF, remainder = rs1.
REQ-022 SHALL treat signed overflow (0x80000000 / 0xFFFFFFFF) specially: go directly to DONE, out_valid in N+1, quotient 0x80000000, remainder 0.
REQ-023 SHALL make RV_32M_UNDEF go directly to DONE with out_result 0 and out_illegal 1, out_valid in N+1.
REQ-024 SHALL hold out_result, out_tag and out_illegal stable while out_valid && !out_ready.
REQ-025 SHALL leave DONE on out_valid && out_ready: next state is IDLE, or MUL/DIV/DONE when a new request is accepted in the same cycle.
REQ-026 SHALL make flush high at any edge force IDLE and out_valid 0 next cycle; flush takes priority over acceptance and completion.
REQ-027 SHALL use an iteration counter that is 6 bits wide, is cleared on entry to MUL/DIV, and exits at count 31.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously set state IDLE, counter 0, out_valid 0, out_result 0, out_tag 0, out_illegal 0 and busy 0.
REQ-029 SHALL discard any operation in flight when reset is asserted mid-operation, with no output produced.

Configuration
REQ-030 SHALL, when RV_MULDIV_FAST_MUL_EN is defined, compute multiplies with a single-cycle 33×33 signed multiplier, go from IDLE directly to DONE with out_valid in N+1, and never enter MUL.
REQ-031 SHALL, without RV_MULDIV_FAST_MUL_EN, use the iterative MUL behaviour of REQ-017; division is iterative in both builds.

Structure
REQ-032 SHALL reuse rv_inst_32m from package rv_inst; constants RV_DIV_ZERO_QUOTIENT (0xFFFFFFFF) and RV_INT32_MIN (0x80000000) SHALL be added to rv_inst.
REQ-033 SHALL keep the FSM state enum local to the module.
REQ-034 SHALL contain one combinational sub-module, rv_muldiv_step, that performs one shift-add or shift-subtract iteration.

Verification
REQ-035 SHALL verify DIV rs1=7, rs2=0xFFFFFFFE -> out_result 0xFFFFFFFD at N+33; REM with the same operands -> 0x00000001.
REQ-036 SHALL verify MULH 0x80000000×0x80000000 -> 0x40000000 (and MULHU -> 0x40000000, MULHSU -> 0xC0000000) at N+33, or at N+1 with RV_MULDIV_FAST_MUL_EN.
REQ-037 SHALL verify DIVU 5/0 -> 0xFFFFFFFF at N+1, REMU 5/0 -> 5, and DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1.
REQ-038 SHALL verify that flush during DIV at N+10 gives no out_valid, busy low at N+11, and a request accepted at N+11 completing normally.
REQ-039 SHALL verify out_ready held low 5 cycles in DONE keeps the result stable, and that out_ready with in_valid together in the same cycle accepts back-to-back with no IDLE gap.
REQ-040 SHALL verify RV_32M_UNDEF -> out_illegal 1 and out_result 0 at N+1, and that rst_n pulsed low mid-MUL gives all outputs 0 immediately.

Source files
------------

// File: rtl/rv_inst_pkg.sv
// Shared RV32M operation encoding and constants.
// Used by the iterative multiply/divide unit.
package rv_inst;

    typedef enum logic [3:0] {
        RV_MUL       = 4'd0,
        RV_MULH      = 4'd1,
        RV_MULHSU    = 4'd2,
        RV_MULHU     = 4'd3,
        RV_DIV       = 4'd4,
        RV_DIVU      = 4'd5,
        RV_REM       = 4'd6,
        RV_REMU      = 4'd7,
        RV_32M_UNDEF = 4'd8
    } rv_inst_32m;

    localparam logic [31:0] RV_DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [31:0] RV_INT32_MIN         = 32'h8000_0000;

    function automatic logic [31:0] rv_mag(input logic [31:0] x,
                                           input logic        sgn);
        return (sgn && x[31]) ? -x : x;
    endfunction

endpackage

// File: rtl/rv_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring
// shift-subtract divide on a {hi,lo} accumulator pair.
module rv_muldiv_step (
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] b,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt
);

    logic [32:0] sum;
    logic [32:0] shl;
    logic        ge;

    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : 33'd0);
        shl = {hi, lo[31]};
        ge  = shl >= {1'b0, b};
        if (is_div) begin
            hi_nxt = ge ? 32'(shl - {1'b0, b}) : shl[31:0];
            lo_nxt = {lo[30:0], ge};
        end else begin
            hi_nxt = sum[32:1];
            lo_nxt = {sum[0], lo[31:1]};
        end
    end

endmodule

// File: rtl/rv_muldiv_seq.sv
// Sequential RV32M multiply/divide unit with valid/ready handshakes.
// Define RV_MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module rv_muldiv_seq
    import rv_inst::*;
#(
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  rv_inst_32m           in_op,
    input  logic [31:0]          in_rs1,
    input  logic [31:0]          in_rs2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_illegal,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE, S_MUL, S_DIV, S_DONE
    } state_t;

    state_t      state, state_n, entry;
    logic [5:0]  cnt;
    rv_inst_32m  op_q;
    logic        neg_q, rneg_q;
    logic [31:0] hi, lo, b_q;
    logic [31:0] hi_nxt, lo_nxt;
    logic [31:0] a_mag, b_mag, imm_res, fin_res;
    logic [63:0] prod;
    logic        s1, s2, in_mul, in_div, is_rem, ill;
    logic        div_zero, div_ovf, imm;
    logic        accept, last, iter;

    assign in_ready  = !flush && (state == S_IDLE ||
                       (state == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = state == S_DONE;
    assign busy      = state != S_IDLE;
    assign last      = cnt == 6'd31;
    assign iter      = !flush && (state == S_MUL || state == S_DIV);

    always_comb begin
        s1 = in_op inside {RV_MUL, RV_MULH, RV_MULHSU,
                           RV_DIV, RV_REM};
        s2 = in_op inside {RV_MUL, RV_MULH, RV_DIV, RV_REM};
        in_mul = in_op inside {RV_MUL, RV_MULH, RV_MULHSU, RV_MULHU};
        in_div = in_op inside {RV_DIV, RV_DIVU, RV_REM, RV_REMU};
        is_rem = in_op inside {RV_REM, RV_REMU};
        ill    = !in_mul && !in_div;
        div_zero = in_rs2 == 32'd0;
        div_ovf  = s1 && in_rs1 == RV_INT32_MIN && in_rs2 == '1;
        a_mag    = rv_mag(in_rs1, s1);
        b_mag    = rv_mag(in_rs2, s2);
    end

`ifdef RV_MULDIV_FAST_MUL_EN
    logic [63:0] fprod;
    assign fprod = {{32{s1 & in_rs1[31]}}, in_rs1} *
                   {{32{s2 & in_rs2[31]}}, in_rs2};
`endif

    // Operations that resolve without iterating go straight to DONE.
    always_comb begin
        imm     = 1'b1;
        imm_res = '0;
        unique case (1'b1)
            in_mul: begin
`ifdef RV_MULDIV_FAST_MUL_EN
                imm_res = (in_op == RV_MUL) ? fprod[31:0] : fprod[63:32];
`else
                imm = 1'b0;
`endif
            end
            in_div && div_zero:
                imm_res = is_rem ? in_rs1 : RV_DIV_ZERO_QUOTIENT;
            in_div && div_ovf:
                imm_res = is_rem ? 32'd0 : RV_INT32_MIN;
            in_div && !div_zero && !div_ovf:
                imm = 1'b0;
            default: imm_res = '0;
        endcase
        entry = imm ? S_DONE : (in_mul ? S_MUL : S_DIV);
    end

    rv_muldiv_step u_step (
        .is_div (state == S_DIV),
        .hi     (hi),
        .lo     (lo),
        .b      (b_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    always_comb begin
        prod    = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        fin_res = '0;
        unique case (op_q)
            RV_MUL:                       fin_res = prod[31:0];
            RV_MULH, RV_MULHSU, RV_MULHU: fin_res = prod[63:32];
            RV_DIV, RV_DIVU:  fin_res = neg_q ? -lo_nxt : lo_nxt;
            RV_REM, RV_REMU:  fin_res = rneg_q ? -hi_nxt : hi_nxt;
            default:          fin_res = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (accept) state_n = entry;
            S_MUL, S_DIV: if (last) state_n = S_DONE;
            S_DONE: if (out_ready) state_n = accept ? entry : S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            op_q        <= RV_MUL;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            b_q         <= '0;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            op_q        <= in_op;
            out_tag     <= in_tag;
            out_illegal <= ill;
            neg_q       <= (s1 & in_rs1[31]) ^ (s2 & in_rs2[31]);
            rneg_q      <= s1 & in_rs1[31];
            hi          <= '0;
            lo          <= in_mul ? b_mag : a_mag;
            b_q         <= in_mul ? a_mag : b_mag;
            if (imm) out_result <= imm_res;
        end else if (iter) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + 6'd1;
            if (last) out_result <= fin_res;
        end
    end

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Scoreboard bench for rv_muldiv_seq: directed corner cases
// followed by randomized traffic with random output backpressure.
module tb_rv_muldiv_seq;
    import rv_inst::*;

    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    rv_inst_32m    in_op = RV_MUL;
    logic [31:0]   in_rs1 = '0;
    logic [31:0]   in_rs2 = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_result;
    logic [TW-1:0] out_tag;
    logic          out_illegal;
    logic          busy;

    typedef struct {
        logic [31:0]   res;
        logic [TW-1:0] tag;
        logic          ill;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   rnd_ready = 0;

    rv_muldiv_seq #(.TAG_WIDTH(TW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = ($urandom % 4) != 0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference results straight from the RV32M arithmetic rules.
    function automatic logic [31:0] model(input rv_inst_32m op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            RV_MUL:    begin p = sa * sb; return p[31:0];  end
            RV_MULH:   begin p = sa * sb; return p[63:32]; end
            RV_MULHSU: begin p = sa * ub; return p[63:32]; end
            RV_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            RV_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            RV_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                p = sa % sb; return p[31:0];
            end
            RV_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            RV_REMU: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat(input rv_inst_32m op,
                               input logic [31:0] a,
                               input logic [31:0] b);
        bit sgn;
        sgn = (op == RV_DIV) || (op == RV_REM);
        if (op inside {RV_MUL, RV_MULH, RV_MULHSU, RV_MULHU}) begin
`ifdef RV_MULDIV_FAST_MUL_EN
            return 0;
`else
            return 32;
`endif
        end
        if (op inside {RV_DIV, RV_DIVU, RV_REM, RV_REMU}) begin
            if (b == 0) return 0;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return 32;
        end
        return 0;
    endfunction

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic issue(input rv_inst_32m op, input logic [31:0] a,
                         input logic [31:0] b, input bit set_ready);
        exp_t e;
        int   n;
        n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = TW'($urandom_range(1, (1 << TW) - 1));
        if (set_ready) out_ready = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles", n);
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
        end
        e.res = model(op, a, b);
        e.tag = in_tag;
        e.ill = (op == RV_32M_UNDEF);
        e.due = cyc + 1 + lat(op, a, b);
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: result %h tag %h",
                         out_result, out_tag);
            end else begin
                chk("result", out_result, exp_q[0].res);
                chk("tag", 32'(out_tag), 32'(exp_q[0].tag));
                chk("illegal", 32'(out_illegal), 32'(exp_q[0].ill));
                if (!seen) begin
                    chk("latency", 32'(cyc), 32'(exp_q[0].due));
                    seen = 1;
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int n;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(RV_DIV, 32'd7, 32'hFFFF_FFFE, 0);
        issue(RV_REM, 32'd7, 32'hFFFF_FFFE, 0);
        issue(RV_MULH, 32'h8000_0000, 32'h8000_0000, 0);
        issue(RV_MULHU, 32'h8000_0000, 32'h8000_0000, 0);
        issue(RV_MULHSU, 32'h8000_0000, 32'h8000_0000, 0);
        issue(RV_DIVU, 32'd5, 32'd0, 0);
        issue(RV_REMU, 32'd5, 32'd0, 0);
        issue(RV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(RV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(RV_32M_UNDEF, 32'h1234_5678, 32'd9, 0);
        issue(RV_MUL, 32'hFFFF_FFFD, 32'd7, 0);
        drain(200);

        // Backpressure then back-to-back handoff from DONE.
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(RV_DIVU, 32'd1000, 32'd7, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid", 32'(out_valid), 32'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        issue(RV_REM, 32'hFFFF_FF00, 32'd3, 1);
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_queue", 32'(exp_q.size()), 32'd1);
        @(posedge clk); #1;
        drain(200);

        // Flush in the middle of a divide.
        @(posedge clk); #1;
        issue(RV_DIV, 32'd100, 32'd7, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        seen = 0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        issue(RV_DIVU, 32'd100, 32'd7, 0);
        drain(200);

        // Reset in the middle of a multiply.
        @(posedge clk); #1;
        issue(RV_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_q.delete();
        seen = 0;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_result", out_result, 32'd0);
        chk("mrst_out_tag", 32'(out_tag), 32'd0);
        chk("mrst_out_illegal", 32'(out_illegal), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("mrst_idle", 32'(busy), 32'd0);

        // Randomized traffic with random out_ready.
        rnd_ready = 1;
        for (int i = 0; i < 80; i++) begin
            rv_inst_32m op;
            op = rv_inst_32m'($urandom_range(0, 8));
            issue(op, pick(), pick(), 0);
            repeat ($urandom % 3) begin
                @(posedge clk); #1;
            end
        end
        rnd_ready = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
